systolic_feeder_2x2: RTL and testbench

Upstream operand feeder for the 2x2 output-stationary systolic array. It accepts one 2x2 A and one 2x2 B matrix per job through a valid/ready handshake and holds them in local registers. It then produces the skewed, zero-padded row and column streams the array edge consumes, and pulses an accumulator clear before each job. After the array pipeline drains, it signals completion so the array's c00..c11 can be sampled.

---
 rtl/systolic_feeder_2x2.sv | 227 ++++++++++++++++++++++
 tb/tb_systolic_feeder_2x2.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder_2x2.sv
// -----------------------------------------------------------------------------
// systolic_feeder_2x2
//
// Operand feeder for a 2x2 output-stationary systolic array. One job is a
// pair of 2x2 matrices A and B. They are accepted through a valid/ready
// handshake and kept in a local operand store. The feeder then:
//   - pulses clear_acc for one cycle so the array zeroes its accumulators,
//   - plays three skewed, zero-padded feed beats on the row/column edges,
//   - idles the edges for DRAIN_CYCLES cycles so the last products propagate,
//   - pulses done for one cycle when the array results are final.
//
// Ports:
//   clk                         rising-edge clock
//   reset                       asynchronous, active-low reset
//   in_valid / in_ready         job handshake (in_ready high only in IDLE)
//   in_a00..in_a11              matrix A, row-major, DATA_W bits each
//   in_b00..in_b11              matrix B, row-major, DATA_W bits each
//   a_row0, a_row1              left-edge A streams into array rows 0 and 1
//   b_col0, b_col1              top-edge B streams into array columns 0 and 1
//   feed_valid                  high on the three feed beats
//   clear_acc                   one-cycle accumulator clear before each job
//   busy                        a job is in progress
//   done                        one-cycle pulse, array results are final
//
// All outputs except in_ready are decoded only from the state register, the
// beat counter and the operand store, so no in_* input reaches them
// combinationally. Operands pass through unsigned and unmodified.
// -----------------------------------------------------------------------------
module systolic_feeder_2x2 #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned DRAIN_CYCLES = 3   // legal range 1..15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a00,
   input  logic [DATA_W-1:0] in_a01,
   input  logic [DATA_W-1:0] in_a10,
   input  logic [DATA_W-1:0] in_a11,
   input  logic [DATA_W-1:0] in_b00,
   input  logic [DATA_W-1:0] in_b01,
   input  logic [DATA_W-1:0] in_b10,
   input  logic [DATA_W-1:0] in_b11,
   output logic [DATA_W-1:0] a_row0,
   output logic [DATA_W-1:0] a_row1,
   output logic [DATA_W-1:0] b_col0,
   output logic [DATA_W-1:0] b_col1,
   output logic              feed_valid,
   output logic              clear_acc,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [DATA_W-1:0] ZERO       = {DATA_W{1'b0}};
   localparam logic [3:0]        FEED_LAST  = 4'd2;
   // The counter runs 0..DRAIN_CYCLES-1 while draining.
   localparam logic [3:0]        DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

   state_t            state;
   state_t            next_state;
   logic [3:0]        cnt;
   logic [3:0]        cnt_next;
   logic              accept;

   // Operand store, loaded only on an accepted handshake.
   logic [DATA_W-1:0] a00;
   logic [DATA_W-1:0] a01;
   logic [DATA_W-1:0] a10;
   logic [DATA_W-1:0] a11;
   logic [DATA_W-1:0] b00;
   logic [DATA_W-1:0] b01;
   logic [DATA_W-1:0] b10;
   logic [DATA_W-1:0] b11;

   // Ready follows the state; the reset term keeps it low while reset is held
   // so that every output reads 0 during reset and rises on release.
   assign in_ready = (state == IDLE) && reset;
   assign accept   = (state == IDLE) && in_valid;

   // State register and beat counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
      end
   end

   // Operand store: captured on accept, otherwise held (it is not cleared at
   // DONE, so the last job's operands stay visible until the next accept).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a00 <= ZERO;
         a01 <= ZERO;
         a10 <= ZERO;
         a11 <= ZERO;
         b00 <= ZERO;
         b01 <= ZERO;
         b10 <= ZERO;
         b11 <= ZERO;
      end else if (accept) begin
         a00 <= in_a00;
         a01 <= in_a01;
         a10 <= in_a10;
         a11 <= in_a11;
         b00 <= in_b00;
         b01 <= in_b01;
         b10 <= in_b10;
         b11 <= in_b11;
      end
   end

   // Next-state and counter sequencing.
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = CLEAR;
               cnt_next   = 4'd0;
            end else begin
               next_state = IDLE;
               cnt_next   = 4'd0;
            end
         end
         CLEAR: begin
            next_state = FEED;
            cnt_next   = 4'd0;
         end
         FEED: begin
            if (cnt == FEED_LAST) begin
               next_state = DRAIN;
               cnt_next   = 4'd0;
            end else begin
               next_state = FEED;
               cnt_next   = cnt + 4'd1;
            end
         end
         DRAIN: begin
            if (cnt == DRAIN_LAST) begin
               next_state = DONE;
               cnt_next   = 4'd0;
            end else begin
               next_state = DRAIN;
               cnt_next   = cnt + 4'd1;
            end
         end
         DONE: begin
            next_state = IDLE;
            cnt_next   = 4'd0;
         end
         default: begin
            next_state = IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   // Output decode. Row i is delayed i beats and column j is delayed j beats,
   // so the matching operand pairs meet at PE(i,j) on the same cycle; slots
   // outside the skew window are padded with zero.
   always_comb begin
      a_row0     = ZERO;
      a_row1     = ZERO;
      b_col0     = ZERO;
      b_col1     = ZERO;
      feed_valid = 1'b0;
      clear_acc  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
         end
         CLEAR: begin
            busy      = 1'b1;
            clear_acc = 1'b1;
         end
         FEED: begin
            busy       = 1'b1;
            feed_valid = 1'b1;
            case (cnt)
               4'd0: begin
                  a_row0 = a00;
                  b_col0 = b00;
               end
               4'd1: begin
                  a_row0 = a01;
                  a_row1 = a10;
                  b_col0 = b10;
                  b_col1 = b01;
               end
               4'd2: begin
                  a_row1 = a11;
                  b_col1 = b11;
               end
               default: begin
                  feed_valid = 1'b0;
               end
            endcase
         end
         DRAIN: begin
            busy = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder_2x2
//
// Directed bench for systolic_feeder_2x2. A small 2x2 output-stationary array
// model consumes the feeder's streams each cycle; results are compared with
// hand-computed matrix products when done pulses.
// -----------------------------------------------------------------------------
module tb_systolic_feeder_2x2;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a00, in_a01, in_a10, in_a11;
   logic [7:0] in_b00, in_b01, in_b10, in_b11;
   logic [7:0] a_row0, a_row1, b_col0, b_col1;
   logic       feed_valid, clear_acc, busy, done;

   int checks = 0;
   int passed = 0;

   // Array model state: pipeline registers and accumulators per PE.
   int unsigned     ar [2][2];
   int unsigned     br [2][2];
   longint unsigned acc[2][2];

   systolic_feeder_2x2 #(.DATA_W(8), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a00(in_a00), .in_a01(in_a01), .in_a10(in_a10), .in_a11(in_a11),
      .in_b00(in_b00), .in_b01(in_b01), .in_b10(in_b10), .in_b11(in_b11),
      .a_row0(a_row0), .a_row1(a_row1), .b_col0(b_col0), .b_col1(b_col1),
      .feed_valid(feed_valid), .clear_acc(clear_acc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Advance to the next falling edge and clock the array model once.
   task automatic step();
      int unsigned ai[2][2];
      int unsigned bi[2][2];
      @(negedge clk);
      if (!reset || clear_acc) begin
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
               ar[i][j] = 0; br[i][j] = 0; acc[i][j] = 0;
            end
      end else begin
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
               ai[i][j] = (j == 0) ? ((i == 0) ? int'(a_row0) : int'(a_row1)) : ar[i][0];
               bi[i][j] = (i == 0) ? ((j == 0) ? int'(b_col0) : int'(b_col1)) : br[0][j];
               acc[i][j] = acc[i][j] + longint'(ai[i][j]) * longint'(bi[i][j]);
            end
         ar = ai;
         br = bi;
      end
   endtask

   task automatic offer(input logic [7:0] a00, a01, a10, a11, b00, b01, b10, b11);
      in_a00 = a00; in_a01 = a01; in_a10 = a10; in_a11 = a11;
      in_b00 = b00; in_b01 = b01; in_b10 = b10; in_b11 = b11;
      in_valid = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      offer(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      in_valid = 1'b0;
      #12;
      checks++;
      if ({a_row0, a_row1, b_col0, b_col1, feed_valid, clear_acc, busy, done, in_ready} !== 37'd0)
         $display("FAIL reset_outputs: got %h want 0",
                  {a_row0, a_row1, b_col0, b_col1, feed_valid, clear_acc, busy, done, in_ready});
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({in_ready, busy} !== 2'b10) $display("FAIL reset_release: ready/busy got %b want 10", {in_ready, busy});
      else passed++;
      step();
      checks++;
      if ({a_row0, a_row1, b_col0, b_col1, done} !== 33'd0)
         $display("FAIL idle_outputs: got %h want 0", {a_row0, a_row1, b_col0, b_col1, done});
      else passed++;
   endtask

   task automatic test_single_and_busy();
      logic [31:0] exp_s[3];
      exp_s[0] = {8'd2, 8'd0, 8'd6, 8'd0};
      exp_s[1] = {8'd3, 8'd4, 8'd8, 8'd7};
      exp_s[2] = {8'd0, 8'd5, 8'd0, 8'd9};
      offer(8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
      for (int n = 1; n <= 9; n++) begin
         step();
         if (n == 1) begin
            in_valid = 1'b0;
            checks++;
            if ({clear_acc, in_ready, busy, feed_valid} !== 4'b1010)
               $display("FAIL single_clear: clr/rdy/busy/fv got %b want 1010", {clear_acc, in_ready, busy, feed_valid});
            else passed++;
         end
         if (n >= 2 && n <= 4) begin
            checks++;
            if ({a_row0, a_row1, b_col0, b_col1} !== exp_s[n-2] || feed_valid !== 1'b1)
               $display("FAIL single_beat%0d: got %h fv %b want %h fv 1", n-2,
                        {a_row0, a_row1, b_col0, b_col1}, feed_valid, exp_s[n-2]);
            else passed++;
         end
         // Offer an all-ones job during FEED; it must be ignored.
         if (n == 2) offer(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
         if (n == 3) begin
            checks++;
            if (in_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", in_ready);
            else passed++;
         end
         if (n == 4) in_valid = 1'b0;
         if (n == 5) begin
            checks++;
            if ({a_row0, a_row1, b_col0, b_col1, feed_valid} !== 33'd0)
               $display("FAIL single_drain: got %h want 0", {a_row0, a_row1, b_col0, b_col1, feed_valid});
            else passed++;
         end
         if (n == 7) begin
            checks++;
            if (done !== 1'b0) $display("FAIL single_early_done: got %b want 0", done);
            else passed++;
         end
         if (n == 8) begin
            checks++;
            if (done !== 1'b1) $display("FAIL single_done: got %b want 1", done);
            else passed++;
            checks++;
            if (acc[0][0] != 36 || acc[0][1] != 41 || acc[1][0] != 64 || acc[1][1] != 73)
               $display("FAIL single_result: got %0d %0d %0d %0d want 36 41 64 73",
                        acc[0][0], acc[0][1], acc[1][0], acc[1][1]);
            else passed++;
         end
         if (n == 9) begin
            checks++;
            if ({done, in_ready, busy} !== 3'b010)
               $display("FAIL single_idle: done/rdy/busy got %b want 010", {done, in_ready, busy});
            else passed++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_s[3];
      exp_s[0] = {8'd1, 8'd0, 8'd9, 8'd0};
      exp_s[1] = {8'd0, 8'd0, 8'd7, 8'd8};
      exp_s[2] = {8'd0, 8'd1, 8'd0, 8'd6};
      offer(8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
      for (int n = 1; n <= 18; n++) begin
         step();
         if (n == 1) offer(8'd1, 8'd0, 8'd0, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6);
         if (n == 8) begin
            checks++;
            if (done !== 1'b1 || acc[0][0] != 36 || acc[0][1] != 41 || acc[1][0] != 64 || acc[1][1] != 73)
               $display("FAIL b2b_first: done %b res %0d %0d %0d %0d want 1 36 41 64 73",
                        done, acc[0][0], acc[0][1], acc[1][0], acc[1][1]);
            else passed++;
         end
         if (n == 9) begin
            checks++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", in_ready);
            else passed++;
         end
         if (n == 10) begin
            in_valid = 1'b0;
            checks++;
            if ({clear_acc, in_ready} !== 2'b10)
               $display("FAIL b2b_clear: clr/rdy got %b want 10", {clear_acc, in_ready});
            else passed++;
         end
         if (n >= 11 && n <= 13) begin
            checks++;
            if ({a_row0, a_row1, b_col0, b_col1} !== exp_s[n-11])
               $display("FAIL b2b_beat%0d: got %h want %h", n-11, {a_row0, a_row1, b_col0, b_col1}, exp_s[n-11]);
            else passed++;
         end
         if (n == 17) begin
            checks++;
            if (done !== 1'b1 || acc[0][0] != 9 || acc[0][1] != 8 || acc[1][0] != 7 || acc[1][1] != 6)
               $display("FAIL b2b_second: done %b res %0d %0d %0d %0d want 1 9 8 7 6",
                        done, acc[0][0], acc[0][1], acc[1][0], acc[1][1]);
            else passed++;
         end
      end
   endtask

   task automatic test_max_values();
      logic [31:0] exp_s[3];
      exp_s[0] = {8'hFF, 8'h00, 8'hFF, 8'h00};
      exp_s[1] = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
      exp_s[2] = {8'h00, 8'hFF, 8'h00, 8'hFF};
      offer(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      for (int n = 1; n <= 9; n++) begin
         step();
         if (n == 1) in_valid = 1'b0;
         if (n >= 2 && n <= 4) begin
            checks++;
            if ({a_row0, a_row1, b_col0, b_col1} !== exp_s[n-2])
               $display("FAIL max_beat%0d: got %h want %h", n-2, {a_row0, a_row1, b_col0, b_col1}, exp_s[n-2]);
            else passed++;
         end
         // 2 * 255 * 255 = 130050 (17'h1FC02) for every element.
         if (n == 8) begin
            checks++;
            if (done !== 1'b1 || acc[0][0] != 130050 || acc[0][1] != 130050 ||
                acc[1][0] != 130050 || acc[1][1] != 130050)
               $display("FAIL max_result: done %b res %0d %0d %0d %0d want 1 and 130050 each",
                        done, acc[0][0], acc[0][1], acc[1][0], acc[1][1]);
            else passed++;
         end
      end
   endtask

   task automatic test_abort();
      bit seen_done = 1'b0;
      offer(8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
      for (int n = 1; n <= 3; n++) begin
         step();
         if (n == 1) in_valid = 1'b0;
      end
      checks++;
      if ({a_row0, a_row1, b_col0, b_col1} !== {8'd3, 8'd4, 8'd8, 8'd7})
         $display("FAIL abort_pre: got %h want 03040807", {a_row0, a_row1, b_col0, b_col1});
      else passed++;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({a_row0, a_row1, b_col0, b_col1, feed_valid, clear_acc, busy, done, in_ready} !== 37'd0)
         $display("FAIL abort_outputs: got %h want 0",
                  {a_row0, a_row1, b_col0, b_col1, feed_valid, clear_acc, busy, done, in_ready});
      else passed++;
      step();
      step();
      reset = 1'b1;
      for (int n = 0; n < 10; n++) begin
         step();
         if (done === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) $display("FAIL abort_no_done: got done pulse want none");
      else passed++;
      offer(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
      for (int n = 1; n <= 9; n++) begin
         step();
         if (n == 1) begin
            in_valid = 1'b0;
            checks++;
            if (clear_acc !== 1'b1) $display("FAIL abort_fresh_clear: got %b want 1", clear_acc);
            else passed++;
         end
         if (n == 8) begin
            checks++;
            if (done !== 1'b1 || acc[0][0] != 19 || acc[0][1] != 22 || acc[1][0] != 43 || acc[1][1] != 50)
               $display("FAIL abort_fresh_result: done %b res %0d %0d %0d %0d want 1 19 22 43 50",
                        done, acc[0][0], acc[0][1], acc[1][0], acc[1][1]);
            else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_and_busy();
      test_back_to_back();
      test_max_values();
      test_abort();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
